pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clock and reset.
REQ-002 Ports, clock and reset first:
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous active-high reset
- if_stall_req  in  1  IF waiting on an instruction fetch
- id_stall_req  in  1  ID load-use hazard
- mem_stall_req  in  1  MEM waiting on a data access
- ex_branch_miss  in  1  EX resolved a mispredicted branch this cycle
- ex_branch_target  in  32  correct PC for that branch
- if_idle  in  1  IF has no outstanding fetch and can accept a redirect
- stall  out  [5:1]  per-stage hold: 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
- discard_if_id  out  1  kill the IF/ID register contents at the next edge
- discard_id_ex  out  1  kill the ID/EX register contents at the next edge
- redirect_valid  out  1  one-cycle PC redirect strobe to IF
- redirect_pc  out  32  redirect target, valid with redirect_valid
- cnt_stall  out  32  count of cycles with any stall bit set
- cnt_flush  out  32  count of accepted mispredicts

Function
REQ-003 stall SHALL be combinational and derived as follows:
- mem_stall_req sets stall[4:1].
- id_stall_req sets stall[2:1].
- if_stall_req sets stall[1].
- The results are ORed.
- stall[5] is constant 0.
REQ-004 The bubble rule is owned by the pipe registers: stall[k]=1 with stall[k+1]=0 inserts a bubble downstream of stage k. The controller SHALL always produce a contiguous low-order stall mask.
REQ-005 A mispredict is accepted in cycle t when ex_branch_miss=1 and stall[3]=0. When stall[3]=1, ex_branch_miss SHALL be ignored, because EX holds and re-presents it.
REQ-006 In an accept cycle, id_stall_req and if_stall_req SHALL be masked from stall, since they belong to wrong-path instructions. mem_stall_req is never masked.
REQ-007 In an accept cycle, discard_if_id and discard_id_ex SHALL both be 1 (combinational).
REQ-008 The FSM SHALL have two states, NORMAL and PENDING, with a 32-bit pending_pc register:
- NORMAL, accept, if_idle=1: redirect_valid=1 and redirect_pc=ex_branch_target in the same cycle; stay in NORMAL.
- NORMAL, accept, if_idle=0: capture ex_branch_target into pending_pc; go to PENDING at the next edge.
- PENDING: discard_if_id=1 every cycle. stall[2:1] takes only mem_stall_req's contribution; id_stall_req and if_stall_req are masked.
- PENDING, if_idle=1: redirect_valid=1 with redirect_pc=pending_pc; return to NORMAL at the next edge.
- PENDING, new accept: the new target overwrites pending_pc (latest wins). If if_idle=1 in that same cycle, the new target is redirected immediately.
REQ-009 redirect_valid SHALL be high for exactly one cycle per accepted mispredict. When redirect_valid=0, redirect_pc SHALL be 0.
REQ-010 When redirect_valid=0, discard_id_ex SHALL be 0 outside accept cycles.
REQ-011 Counter rules:
- cnt_stall increments in every cycle in which |stall=1.
- cnt_flush increments on every accept.
- Both wrap from 32'hFFFFFFFF to 0.
- Both are registered, with the value visible the cycle after the event.

Reset
REQ-012 While reset=1, the block SHALL force:
- stall=0, discard_if_id=0, discard_id_ex=0, redirect_valid=0, redirect_pc=0, regardless of the other inputs.
- state set to NORMAL at the edge.
- pending_pc=0 and cnt_stall=cnt_flush=0 at the edge.
REQ-013 Reset asserted while in PENDING SHALL drop the pending redirect, with no redirect_valid after reset deasserts.

Verification
REQ-014 Stall composition: drive mem_stall_req=1 and id_stall_req=1 -> stall=5'b01111; drive only id_stall_req -> stall=5'b00011; drive only if_stall_req -> stall=5'b00001.
REQ-015 Immediate redirect: ex_branch_miss=1, target 32'h0000_1040, if_idle=1, no stalls -> in the same cycle both discards=1, redirect_valid=1 and redirect_pc=32'h0000_1040; next cycle cnt_flush=1.
REQ-016 Deferred redirect: miss with target 32'h0000_2000 and if_idle=0 held for 3 cycles, then if_idle=1 -> discard_if_id=1 for 4 cycles; redirect_valid pulses once, with pc 32'h0000_2000, in the if_idle cycle; state returns to NORMAL.
REQ-017 Miss under MEM stall: mem_stall_req=1 and ex_branch_miss=1 for 2 cycles, then mem_stall_req=0 -> no discard or redirect while stalled; a single accept on the third cycle; cnt_flush=1.
REQ-018 Overwrite and reset: while in PENDING with target A, a new miss with target B arrives and if_idle=0 -> a later redirect carries B. A separate run asserts reset while in PENDING -> no redirect ever, and both counters=0.
REQ-019 Counter wrap: preload, or run until cnt_stall=32'hFFFFFFFF, then one stall cycle -> cnt_stall=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: composes per-stage stall masks, accepts branch
// mispredicts from EX, kills wrong-path IF/ID/EX contents and steers IF to the
// corrected PC, deferring the redirect until IF reports it is idle.
// Latency: stall/discard/redirect outputs are combinational from the current
// inputs and state. Counters are registered and show an event one cycle later.
// Backpressure: a mispredict presented while EX is held is ignored, because EX
// re-presents it once it moves. A redirect is held in PENDING until if_idle.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   *_stall_req                       - stall requests from IF, ID and MEM
//   ex_branch_miss, ex_branch_target  - mispredict strobe and corrected PC
//   if_idle                           - IF can take a redirect this cycle
//   stall[5:1]                        - per-stage hold mask (1=IF .. 5=WB)
//   discard_if_id, discard_id_ex      - kill pipe register contents at the next edge
//   redirect_valid, redirect_pc       - one-cycle PC redirect to IF
//   cnt_stall, cnt_flush              - stall-cycle and accepted-mispredict counters
module pipe_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_branch_miss,
    input  logic [31:0] ex_branch_target,
    input  logic        if_idle,
    output logic [5:1]  stall,
    output logic        discard_if_id,
    output logic        discard_id_ex,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
);

    typedef enum logic {NORMAL, PENDING} state_t;

    state_t      state;
    logic [31:0] pending_pc;
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_flush_q;
    logic        accept;
    logic        wrong_path;

    always_comb begin
        accept         = 1'b0;
        wrong_path     = 1'b0;
        stall          = 5'b00000;
        discard_if_id  = 1'b0;
        discard_id_ex  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (!reset) begin
            // EX is held (stall[3]) only by a MEM stall, so that alone
            // decides whether the mispredict can be taken this cycle.
            accept     = ex_branch_miss && !mem_stall_req;
            // IF/ID hold wrong-path instructions from the accept cycle until
            // the redirect is delivered; their stall requests are meaningless.
            wrong_path = accept || (state == PENDING);

            stall[4:1] = {4{mem_stall_req}};
            if (!wrong_path) begin
                stall[2] = stall[2] | id_stall_req;
                stall[1] = stall[1] | id_stall_req | if_stall_req;
            end

            discard_if_id = wrong_path;
            discard_id_ex = accept;

            // A fresh accept beats an older pending target (latest wins).
            if (accept && if_idle) begin
                redirect_valid = 1'b1;
                redirect_pc    = ex_branch_target;
            end else if ((state == PENDING) && if_idle) begin
                redirect_valid = 1'b1;
                redirect_pc    = pending_pc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= NORMAL;
            pending_pc  <= 32'h0;
            cnt_stall_q <= 32'h0;
            cnt_flush_q <= 32'h0;
        end else begin
            cnt_stall_q <= cnt_stall_q + {31'b0, |stall};
            cnt_flush_q <= cnt_flush_q + {31'b0, accept};
            if (accept && !if_idle) begin
                state      <= PENDING;
                pending_pc <= ex_branch_target;
            end else if (if_idle) begin
                state <= NORMAL;
            end
        end
    end

    assign cnt_stall = cnt_stall_q;
    assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the rules.
module tb_pipe_ctrl;

    logic        clock;
    logic        reset;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        mem_stall_req;
    logic        ex_branch_miss;
    logic [31:0] ex_branch_target;
    logic        if_idle;
    logic [5:1]  stall;
    logic        discard_if_id;
    logic        discard_id_ex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;

    pipe_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .if_stall_req     (if_stall_req),
        .id_stall_req     (id_stall_req),
        .mem_stall_req    (mem_stall_req),
        .ex_branch_miss   (ex_branch_miss),
        .ex_branch_target (ex_branch_target),
        .if_idle          (if_idle),
        .stall            (stall),
        .discard_if_id    (discard_if_id),
        .discard_id_ex    (discard_id_ex),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .cnt_stall        (cnt_stall),
        .cnt_flush        (cnt_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: is a redirect owed to IF, and to where.
    bit          m_owed;
    logic [31:0] m_owed_pc;
    logic [31:0] m_cs;
    logic [31:0] m_cf;

    // Observations of the last cycle, for directed checks and tallies.
    logic [5:1]  o_stall;
    logic        o_dif, o_dex, o_rv;
    logic [31:0] o_rpc;
    int          n_rv, n_dif, n_dex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check all outputs on the falling edge against
    // the model, then advance the model across the rising edge.
    task automatic cyc(input logic rst, input logic ifs, input logic ids, input logic mems,
                       input logic miss, input logic [31:0] tgt, input logic idle);
        logic [5:1]  e_stall;
        logic        e_dif, e_dex, e_rv, acc;
        logic [31:0] e_rpc;
        reset = rst; if_stall_req = ifs; id_stall_req = ids; mem_stall_req = mems;
        ex_branch_miss = miss; ex_branch_target = tgt; if_idle = idle;
        @(negedge clock);
        e_stall = 5'b0; e_dif = 1'b0; e_dex = 1'b0; e_rv = 1'b0; e_rpc = 32'h0; acc = 1'b0;
        if (!rst) begin
            acc = miss && !mems;
            if (mems) e_stall = 5'b01111;
            if (!(acc || m_owed)) begin
                if (ids) e_stall = e_stall | 5'b00011;
                if (ifs) e_stall = e_stall | 5'b00001;
            end
            e_dif = acc || m_owed;
            e_dex = acc;
            if (idle && acc)         begin e_rv = 1'b1; e_rpc = tgt;       end
            else if (idle && m_owed) begin e_rv = 1'b1; e_rpc = m_owed_pc; end
        end
        chk("stall",          {27'b0, stall},          {27'b0, e_stall});
        chk("discard_if_id",  {31'b0, discard_if_id},  {31'b0, e_dif});
        chk("discard_id_ex",  {31'b0, discard_id_ex},  {31'b0, e_dex});
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
        chk("redirect_pc",    redirect_pc,             e_rpc);
        chk("cnt_stall",      cnt_stall,               m_cs);
        chk("cnt_flush",      cnt_flush,               m_cf);
        o_stall = stall; o_dif = discard_if_id; o_dex = discard_id_ex;
        o_rv = redirect_valid; o_rpc = redirect_pc;
        n_rv  += int'(redirect_valid);
        n_dif += int'(discard_if_id);
        n_dex += int'(discard_id_ex);
        if (rst) begin
            m_owed = 1'b0; m_owed_pc = 32'h0; m_cs = 32'h0; m_cf = 32'h0;
        end else begin
            if (e_stall != 5'b0) m_cs = m_cs + 32'd1;
            if (acc) m_cf = m_cf + 32'd1;
            if (acc && !idle) begin m_owed = 1'b1; m_owed_pc = tgt; end
            else if (idle)    m_owed = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clr_tally();
        n_rv = 0; n_dif = 0; n_dex = 0;
    endtask

    initial begin
        m_owed = 1'b0; m_owed_pc = 32'h0; m_cs = 32'h0; m_cf = 32'h0;
        clr_tally();
        // Reset, with every input active to show it is overridden.
        cyc(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 1);
        chk("reset_stall", {27'b0, o_stall}, 32'h0);
        chk("reset_rv",    {31'b0, o_rv},    32'h0);
        cyc(1, 0, 0, 0, 0, 32'h0, 1);

        // Stall composition.
        cyc(0, 0, 1, 1, 0, 32'h0, 1); chk("comp_mem_id", {27'b0, o_stall}, 32'h0F);
        cyc(0, 0, 1, 0, 0, 32'h0, 1); chk("comp_id",     {27'b0, o_stall}, 32'h03);
        cyc(0, 1, 0, 0, 0, 32'h0, 1); chk("comp_if",     {27'b0, o_stall}, 32'h01);

        // Immediate redirect.
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 1, 32'h0000_1040, 1);
        chk("imm_rv",   {31'b0, o_rv}, 32'h1);
        chk("imm_pc",   o_rpc, 32'h0000_1040);
        chk("imm_disc", {30'b0, o_dif, o_dex}, 32'h3);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("imm_flush", cnt_flush, 32'h1);

        // Deferred redirect: IF busy for 3 cycles, then idle.
        clr_tally();
        cyc(0, 0, 0, 0, 1, 32'h0000_2000, 0);
        cyc(0, 1, 1, 0, 0, 32'h0, 0);
        chk("pend_mask", {27'b0, o_stall}, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 32'h0000_9999, 1);
        chk("def_pc",  o_rpc, 32'h0000_2000);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("def_n_dif", n_dif, 4);
        chk("def_n_rv",  n_rv,  1);
        chk("def_back_normal", {31'b0, o_dif}, 32'h0);

        // Mispredict under MEM stall: taken only once MEM releases.
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        clr_tally();
        cyc(0, 0, 0, 1, 1, 32'h0000_3000, 1);
        cyc(0, 0, 0, 1, 1, 32'h0000_3000, 1);
        chk("mem_n_dex", n_dex, 0);
        chk("mem_n_rv",  n_rv,  0);
        cyc(0, 0, 0, 0, 1, 32'h0000_3000, 1);
        chk("mem_pc", o_rpc, 32'h0000_3000);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("mem_flush", cnt_flush, 32'h1);

        // Overwrite while pending: the later target wins.
        cyc(0, 0, 0, 0, 1, 32'h0000_A000, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_B000, 0);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("ovr_pc", o_rpc, 32'h0000_B000);

        // Reset while pending drops the redirect and clears counters.
        cyc(0, 0, 0, 0, 1, 32'h0000_C000, 0);
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        clr_tally();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("rst_pend_n_rv", n_rv, 0);
        chk("rst_cnt_stall", cnt_stall, 32'h0);
        chk("rst_cnt_flush", cnt_flush, 32'h0);

        // Counter wrap: preload the stall counter at its maximum.
        force dut.cnt_stall_q = 32'hFFFF_FFFF;
        m_cs = 32'hFFFF_FFFF;
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        release dut.cnt_stall_q;
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        chk("wrap_cnt_stall", cnt_stall, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0),
                $urandom,
                ($urandom_range(0, 1) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
